// File: rtl/sync_fifo_traffic_gen.sv
// Traffic generator and checker for a synchronous FIFO.
// Each run writes NUM_WORDS words of PATTERN ^ index and reads them back.
// Every returned word is compared with the expected sequence, and the
// empty/full flags are cross-checked against a local occupancy model.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; results of the last run are held
// S_FILL   | mode 0: writing until the FIFO is full or all words are sent
// S_DRAIN  | mode 0: reading until the FIFO is empty
// S_STREAM | modes 1-3: writing and reading concurrently
// S_FLUSH  | one extra cycle so the final read data is compared
// S_DONE   | pass is resolved; then back to S_IDLE
module sync_fifo_traffic_gen #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 16,
   parameter int                    NUM_WORDS  = 64,
   parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(32'hA5A5_0000),
   parameter logic [15:0]           LFSR_SEED  = 16'hACE1,
   parameter int                    TIMEOUT    = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [1:0]            mode_i,
   output logic                  write_o,
   output logic [DATA_WIDTH-1:0] wData_o,
   output logic                  read_o,
   input  logic [DATA_WIDTH-1:0] rdData_i,
   input  logic                  empty_i,
   input  logic                  full_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic                  timeout_o,
   output logic [15:0]           data_err_count_o,
   output logic [15:0]           flag_err_count_o,
   output logic [15:0]           first_err_index_o
);

   localparam int               OCC_W    = $clog2(DEPTH + 1);
   localparam int               TMR_W    = $clog2(TIMEOUT + 1);
   localparam logic [15:0]      LAST_IDX = 16'(NUM_WORDS);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_DRAIN, S_STREAM, S_FLUSH, S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              mode_q;
   logic [15:0]             wr_idx_q, rd_idx_q;
   logic [OCC_W-1:0]        occ_q;
   logic [15:0]             lfsr_q;
   logic [TMR_W-1:0]        tmr_q;
   logic                    chk_q;
   logic [DATA_WIDTH-1:0]   exp_q;
   logic [15:0]             chk_idx_q;
   logic [15:0]             data_err_q, flag_err_q, first_err_q;
   logic                    done_q, pass_q, timeout_q;

   logic active, wr_gate, rd_gate, wr_ok, rd_ok, wr_en, rd_en, abort, flag_bad;

   assign active   = (state_q == S_FILL) || (state_q == S_DRAIN) ||
                     (state_q == S_STREAM) || (state_q == S_FLUSH);
   assign wr_gate  = (mode_q == 2'd2) ? lfsr_q[0] : 1'b1;
   assign rd_gate  = (mode_q == 2'd2) ? lfsr_q[1] : 1'b1;
   assign wr_ok    = !full_i && (wr_idx_q != LAST_IDX) && wr_gate;
   assign rd_ok    = !empty_i && (rd_idx_q != LAST_IDX) && rd_gate;
   assign flag_bad = (empty_i && full_i) || (empty_i != (occ_q == '0)) ||
                     (full_i != (occ_q == OCC_FULL));

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state and FIFO strobes; a stall timeout overrides every active state.
   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = (mode_i == 2'd0) ? S_FILL : S_STREAM;
         end
         S_FILL: begin
            wr_en = wr_ok;
            if (full_i || (wr_idx_q == LAST_IDX)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            rd_en = rd_ok;
            if (empty_i) state_d = (wr_idx_q != LAST_IDX) ? S_FILL : S_FLUSH;
         end
         S_STREAM: begin
            wr_en = wr_ok;
            rd_en = rd_ok;
            if (rd_idx_q == LAST_IDX) state_d = S_FLUSH;
         end
         S_FLUSH: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (active && !wr_en && !rd_en && (tmr_q == '0)) begin
         abort   = 1'b1;
         state_d = S_DONE;
      end
   end

   // Run bookkeeping: indices, occupancy model, LFSR, stall timer and checks.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q      <= 2'd0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         occ_q       <= '0;
         lfsr_q      <= LFSR_SEED;
         tmr_q       <= TMR_LOAD;
         chk_q       <= 1'b0;
         exp_q       <= '0;
         chk_idx_q   <= '0;
         data_err_q  <= '0;
         flag_err_q  <= '0;
         first_err_q <= 16'hFFFF;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else if ((state_q == S_IDLE) && start_i) begin
         mode_q      <= mode_i;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         occ_q       <= '0;
         tmr_q       <= TMR_LOAD;
         chk_q       <= 1'b0;
         data_err_q  <= '0;
         flag_err_q  <= '0;
         first_err_q <= 16'hFFFF;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else if (active) begin
         if (wr_en) wr_idx_q <= wr_idx_q + 16'd1;
         if (rd_en) rd_idx_q <= rd_idx_q + 16'd1;
         if (wr_en && !rd_en)      occ_q <= occ_q + OCC_W'(1);
         else if (rd_en && !wr_en) occ_q <= occ_q - OCC_W'(1);
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         if (wr_en || rd_en)  tmr_q <= TMR_LOAD;
         else if (!abort)     tmr_q <= tmr_q - TMR_W'(1);
         if (abort) timeout_q <= 1'b1;
         chk_q     <= rd_en;
         exp_q     <= PATTERN ^ DATA_WIDTH'(rd_idx_q);
         chk_idx_q <= rd_idx_q;
         if (chk_q && (rdData_i != exp_q)) begin
            if (data_err_q != 16'hFFFF) data_err_q <= data_err_q + 16'd1;
            if (data_err_q == '0)       first_err_q <= chk_idx_q;
         end
         if (flag_bad && (flag_err_q != 16'hFFFF)) flag_err_q <= flag_err_q + 16'd1;
      end else if (state_q == S_DONE) begin
         chk_q  <= 1'b0;
         done_q <= 1'b1;
         pass_q <= (data_err_q == '0) && (flag_err_q == '0) && !timeout_q;
      end
   end

   assign write_o           = wr_en;
   assign read_o            = rd_en;
   assign wData_o           = wr_en ? (PATTERN ^ DATA_WIDTH'(wr_idx_q)) : '0;
   assign busy_o            = active;
   assign done_o            = done_q;
   assign pass_o            = pass_q;
   assign timeout_o         = timeout_q;
   assign data_err_count_o  = data_err_q;
   assign flag_err_count_o  = flag_err_q;
   assign first_err_index_o = first_err_q;

endmodule

// File: tb/tb_sync_fifo_traffic_gen.sv
// Bench for sync_fifo_traffic_gen: a behavioural FIFO answers the generator,
// each run pushes its expected result into a scoreboard, and a monitor
// compares the outputs when done rises and checks every written word.
module tb_sync_fifo_traffic_gen;

   localparam int          DW   = 32;
   localparam int          DEP  = 16;
   localparam int          NW   = 200;
   localparam logic [31:0] PATT = 32'hA5A5_0000;

   typedef struct {
      logic [15:0] derr;
      bit          flag_nz;
      logic [15:0] first;
      bit          pass;
      bit          tmo;
      int          reads;
      int          occ_lo, occ_hi;
      int          cyc_lo, cyc_hi;
   } run_exp_t;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [1:0]    mode;
   logic          write, read, empty, full, busy, done, pass, tmo;
   logic [DW-1:0] wdata, rddata;
   logic [15:0]   derr_cnt, ferr_cnt, first_idx;

   int errors = 0;
   int checks = 0;
   run_exp_t sb[$];

   bit inj_data = 1'b0;
   bit inj_full = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_traffic_gen #(
      .DATA_WIDTH(DW), .DEPTH(DEP), .NUM_WORDS(NW), .PATTERN(PATT),
      .LFSR_SEED(16'hACE1), .TIMEOUT(1024)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
      .write_o(write), .wData_o(wdata), .read_o(read), .rdData_i(rddata),
      .empty_i(empty), .full_i(full), .busy_o(busy), .done_o(done),
      .pass_o(pass), .timeout_o(tmo), .data_err_count_o(derr_cnt),
      .flag_err_count_o(ferr_cnt), .first_err_index_o(first_idx)
   );

   // Behavioural FIFO with optional data corruption and a stuck-full flag.
   logic [DW-1:0] mem [DEP];
   logic [3:0]    wp, rp;
   logic [4:0]    cnt;
   int            wcnt, rcnt;
   logic          force_full;
   logic          do_w, do_r;

   assign empty = (cnt == 5'd0);
   assign full  = force_full || (cnt == 5'd16);
   assign do_w  = write && (cnt != 5'd16);
   assign do_r  = read && (cnt != 5'd0);

   always @(posedge clk) begin
      if (rst) begin
         wp <= '0; rp <= '0; cnt <= '0; rddata <= '0;
         wcnt <= 0; rcnt <= 0; force_full <= 1'b0;
      end else begin
         if (start && !busy) begin
            wcnt <= 0; rcnt <= 0; force_full <= 1'b0;
         end
         if (do_w) begin
            mem[wp] <= wdata;
            wp      <= wp + 4'd1;
            wcnt    <= wcnt + 1;
            if (inj_full && wcnt == 2) force_full <= 1'b1;
         end
         if (do_r) begin
            rddata <= mem[rp] ^ ((inj_data && rcnt == 4) ? 32'd1 : 32'd0);
            rp     <= rp + 4'd1;
            rcnt   <= rcnt + 1;
         end
         cnt <= cnt + {4'd0, do_w} - {4'd0, do_r};
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input longint act, input longint lo,
                            input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_write"}, write, 0);
      chk({tag, "_read"}, read, 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_timeout"}, tmo, 0);
      chk({tag, "_derr"}, derr_cnt, 0);
      chk({tag, "_ferr"}, ferr_cnt, 0);
      chk({tag, "_first"}, first_idx, 16'hFFFF);
   endtask

   // Monitor: written-data sequence, per-run statistics, scoreboard on done.
   initial begin
      int       wexp = 0;
      int       nreads = 0;
      int       maxocc = 0;
      int       ncyc = 0;
      logic     busy_prev = 1'b0;
      logic     done_prev = 1'b0;
      run_exp_t e;
      forever begin
         @(negedge clk);
         if (busy && !busy_prev) begin
            wexp = 0; nreads = 0; maxocc = 0; ncyc = 0;
         end
         if (busy) begin
            ncyc++;
            if (int'(cnt) > maxocc) maxocc = int'(cnt);
         end
         if (write) begin
            chk("wdata", wdata, PATT ^ 32'(wexp));
            wexp++;
         end
         if (read) nreads++;
         if (done && !done_prev) begin
            if (sb.size() == 0) begin
               errors++; checks++;
               $display("FAIL sb_unexpected_done: got done with empty scoreboard");
            end else begin
               e = sb.pop_front();
               chk("busy_at_done", busy, 0);
               chk("data_err_count", derr_cnt, e.derr);
               if (e.flag_nz) chk_range("flag_err_count", ferr_cnt, 1, 65535);
               else           chk("flag_err_count", ferr_cnt, 0);
               chk("first_err_index", first_idx, e.first);
               chk("pass", pass, e.pass);
               chk("timeout", tmo, e.tmo);
               chk("reads", nreads, e.reads);
               chk_range("max_occupancy", maxocc, e.occ_lo, e.occ_hi);
               chk_range("busy_cycles", ncyc, e.cyc_lo, e.cyc_hi);
            end
         end
         busy_prev = busy;
         done_prev = done;
      end
   end

   task automatic pulse_start(input logic [1:0] m);
      @(negedge clk);
      mode  = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run(input logic [1:0] m, input run_exp_t e, input int budget);
      int i;
      sb.push_back(e);
      pulse_start(m);
      i = 0;
      while (!done && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (!done) begin
         errors++; checks++;
         $display("FAIL run_done_wait: done=%0b after %0d cycles, required 1", done, budget);
         void'(sb.pop_back());
      end
      repeat (2) @(negedge clk);
   endtask

   function automatic run_exp_t mk(input logic [15:0] derr, input bit fnz,
                                   input logic [15:0] first, input bit p, input bit t,
                                   input int reads, input int olo, input int ohi,
                                   input int clo, input int chi);
      run_exp_t e;
      e.derr = derr; e.flag_nz = fnz; e.first = first; e.pass = p; e.tmo = t;
      e.reads = reads; e.occ_lo = olo; e.occ_hi = ohi; e.cyc_lo = clo; e.cyc_hi = chi;
      return e;
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'd0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Fill-then-drain: 12 bursts of 16 plus one of 8, 427 busy cycles.
      run(2'd0, mk(16'd0, 0, 16'hFFFF, 1, 0, NW, 16, 16, 425, 430), 2000);
      // Streaming: one word in flight, 203 busy cycles.
      run(2'd1, mk(16'd0, 0, 16'hFFFF, 1, 0, NW, 1, 2, 200, 205), 1000);
      // Random gating by LFSR.
      run(2'd2, mk(16'd0, 0, 16'hFFFF, 1, 0, NW, 1, 16, NW, 3000), 5000);
      // Corrupted 5th read word.
      inj_data = 1'b1;
      run(2'd0, mk(16'd1, 0, 16'd4, 0, 0, NW, 16, 16, 425, 430), 2000);
      inj_data = 1'b0;
      // Full stuck high after 3 writes: flag errors then a 1024-cycle stall abort.
      inj_full = 1'b1;
      run(2'd0, mk(16'd0, 1, 16'hFFFF, 0, 1, 3, 3, 3, 1028, 1035), 3000);
      inj_full = 1'b0;

      // Streaming run: a second start while busy is ignored, then reset mid-run.
      pulse_start(2'd1);
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_ignored_start", busy, 1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs("midrun_reset");
      run(2'd1, mk(16'd0, 0, 16'hFFFF, 1, 0, NW, 1, 2, 200, 205), 1000);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
